clk_en_ctrl: RTL
================

Name: clk_en_ctrl

Overview:
- Run/stop and reconfiguration controller for the system-clock divider timebase.
- Owns one shared period counter and sequences it: start/stop with clean period completion, one-shot mode, and a glitch-free divide-ratio update that takes effect only at a period boundary.
- Produces a one-cycle tick enable and a divided square wave whose frequency equals f_clk/div, counting one full period per output cycle (not doubled).
- Sits between the control/keypad logic and any 5 Hz-class consumer (display scan, debounce, blink).

Parameters:
WIDTH, 32, bit width of the divide ratio and period counter
DEF_DIV, 10_000_000, divide ratio loaded at reset (50 MHz -> 5 Hz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  level/pulse; request to begin counting
stop  in  1  level/pulse; request to end after current period
oneshot  in  1  sampled with start in IDLE; 1 = run exactly one period
cfg_valid  in  1  new divide ratio offered
cfg_div  in  WIDTH  divide ratio offered (legal >= 2)
cfg_ready  out  1  controller can accept cfg_div this cycle
cfg_err  out  1  one-cycle pulse: accepted cfg_div was < 2 and discarded
tick  out  1  one-cycle pulse on last cycle of every period
clk_out  out  1  divided square wave, registered
busy  out  1  high in RUN or DRAIN
div_cur  out  WIDTH  divide ratio currently in force

Behaviour:
- Reset, on the rst=1 clock edge:
  - state=IDLE, cnt=0, div_cur=DEF_DIV, pending empty.
  - tick=0, clk_out=0, busy=0, cfg_err=0, cfg_ready=1.
- States:
  - IDLE: cnt held at 0; clk_out=0; tick=0.
  - RUN: cnt increments each cycle and wraps from div_cur-1 to 0.
  - DRAIN: identical counting to RUN; exits at the next wrap.
- Transitions:
  - IDLE & start & !stop -> RUN; oneshot latched into os_flag. First counted cycle has cnt=0.
  - IDLE & start & stop -> stay IDLE (stop wins).
  - RUN & wrap & os_flag -> IDLE.
  - RUN & stop & !wrap -> DRAIN.
  - RUN & stop & wrap -> IDLE.
  - DRAIN & wrap -> IDLE.
  - DRAIN & start & !stop -> RUN, with no counter disturbance (drain cancelled).
  - stop in DRAIN is ignored.
- Wrap is the cycle with cnt==div_cur-1 while in RUN or DRAIN. tick=1 combinationally on exactly that cycle, so a period ending in IDLE still emits its final tick.
- clk_out is registered with half=div_cur>>1:
  - set to 1 at the edge ending cnt==half-1;
  - cleared at the edge ending cnt==div_cur-1.
  - Low phase = half cycles, high phase = div_cur-half cycles; odd div gives a longer high phase.
  - Forced 0 on entry to IDLE.
- Config handshake: a transfer occurs on cfg_valid & cfg_ready.
  - In IDLE: cfg_ready=1; a legal value is written to div_cur at that edge.
  - In RUN/DRAIN: cfg_ready = !pend_valid. A legal value goes to pend_div with pend_valid=1. At the next wrap edge, div_cur<=pend_div and pend_valid<=0, so the new period starts with the new ratio and cnt=0.
  - Illegal value (cfg_div<2): transfer still completes; value discarded; cfg_err=1 for the following cycle; no state change.
  - A transfer on the same cycle as a wrap goes to pending and applies at the following wrap. The wrap in force always uses the old div_cur.
  - Returning to IDLE with pend_valid=1 applies pend_div immediately on that edge.
- Width: cnt and div_cur are WIDTH bits; comparisons are unsigned; half-1 is never computed for div<2 because such values are never stored.
- Reset mid-operation: rst=1 in any state returns everything to reset values on that edge, pending config discarded.

Test Plan:
- DEF_DIV=10 override; reset, start pulse -> tick on cycles 10,20,30 after start; clk_out low 5 / high 5 cycles; busy=1.
- div=7 in IDLE via cfg, start with oneshot=1 -> exactly one tick on the 7th cycle, busy falls the next edge, clk_out low 3 / high 4 then 0.
- RUN div=10, stop at cnt=3 -> DRAIN; tick at cnt=9; IDLE after; no further ticks. Repeat with start at cnt=6 during DRAIN -> continues RUN seamlessly.
- RUN div=10, cfg_div=4 offered at cnt=2 -> accepted; cfg_ready=0 until cnt=9 wrap; subsequent ticks every 4 cycles. Second offer while pending is held off by cfg_ready=0.
- cfg_div=1 in IDLE -> cfg_err pulse next cycle; div_cur unchanged. start+stop together in IDLE -> stays IDLE, no tick.
- rst=1 at cnt=5 in RUN with pending cfg -> next cycle IDLE, div_cur=DEF_DIV, clk_out=0, cfg_ready=1.

Source files
------------

// File: rtl/clk_en_ctrl.sv
// Run/stop sequencer for a shared divide-by-div_cur period counter; emits tick + clk_out.
// Latency: tick is combinational on the last cycle of a period; clk_out and cfg_err are registered one edge later.
// Backpressure: cfg_ready drops while a ratio update is pending in RUN/DRAIN and rises again at the period wrap.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   start, stop, oneshot  run control (stop wins over start; oneshot sampled with start in IDLE)
//   cfg_valid/cfg_ready   divide-ratio handshake carrying cfg_div; cfg_err flags a discarded ratio < 2
//   tick, clk_out         period-end pulse and divided square wave
//   busy, div_cur         running indication and the ratio currently in force
module clk_en_ctrl #(
   parameter int WIDTH   = 32,
   parameter int DEF_DIV = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             tick,
   output logic             clk_out,
   output logic             busy,
   output logic [WIDTH-1:0] div_cur
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] pend_div;
   logic             pend_valid;
   logic             os_flag;

   logic             counting;
   logic             wrap;
   logic             to_idle;
   logic             xfer;
   logic             legal;
   logic [WIDTH-1:0] half;

   assign counting  = (state != IDLE);
   assign wrap      = counting && (cnt == div_cur - ONE);
   assign half      = div_cur >> 1;
   assign legal     = (cfg_div >= TWO);
   // In IDLE a ratio is written straight into div_cur, so there is nothing to hold off.
   assign cfg_ready = (state == IDLE) || !pend_valid;
   assign xfer      = cfg_valid && cfg_ready;
   // The final period still ticks even though the edge that ends it returns to IDLE.
   assign to_idle   = wrap && ((state == DRAIN) || os_flag || stop);

   assign tick      = wrap;
   assign busy      = counting;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         div_cur    <= DEF;
         pend_div   <= '0;
         pend_valid <= 1'b0;
         os_flag    <= 1'b0;
         clk_out    <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         // Illegal ratios still complete the handshake; they are only flagged and dropped.
         cfg_err <= xfer && !legal;

         case (state)
            IDLE: begin
               cnt     <= '0;
               clk_out <= 1'b0;
               if (xfer && legal) begin
                  div_cur <= cfg_div;
               end
               if (start && !stop) begin
                  state   <= RUN;
                  os_flag <= oneshot;
               end
            end

            default: begin // RUN and DRAIN count identically
               if (wrap) begin
                  cnt     <= '0;
                  clk_out <= 1'b0;
                  // The period just ending used the old ratio; the next one starts with the new.
                  if (pend_valid) begin
                     div_cur    <= pend_div;
                     pend_valid <= 1'b0;
                  end
                  if (to_idle) begin
                     // A drain ends at its wrap even if start arrives on that same cycle.
                     state <= IDLE;
                     if (xfer && legal) begin
                        div_cur <= cfg_div;
                     end
                  end else if (xfer && legal) begin
                     pend_div   <= cfg_div;
                     pend_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + ONE;
                  // half >= 1 always, since div_cur is never below 2.
                  if (cnt == half - ONE) begin
                     clk_out <= 1'b1;
                  end
                  if (xfer && legal) begin
                     pend_div   <= cfg_div;
                     pend_valid <= 1'b1;
                  end
                  if (state == RUN && stop) begin
                     state <= DRAIN;
                  end else if (state == DRAIN && start && !stop) begin
                     state <= RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule
